// File: rtl/lif_sched_pkg.sv
// Shared types and helpers for the LIF timestep scheduler: FSM state encoding,
// per-neuron visit length and a one-hot decoder.
package lif_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ENABLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam int DEFAULT_EN_CYCLES = 2;
  localparam int DEFAULT_SETTLE    = 1;

  // One visit = FETCH + EN_CYCLES enable cycles + SETTLE wait cycles + CAPTURE.
  function automatic int visit_len(input int en_cycles, input int settle);
    return en_cycles + settle + 2;
  endfunction

  localparam int VISIT_LEN = visit_len(DEFAULT_EN_CYCLES, DEFAULT_SETTLE);

  function automatic logic [63:0] onehot(input int unsigned idx, input int unsigned n);
    logic [63:0] v;
    v = '0;
    if (idx < n && idx < 64) v = 64'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/lif_timestep_scheduler.sv
// Sweeps one SNN timestep across a layer of LIF neurons sharing a single weight
// memory port: latch inputs, visit each neuron in turn, publish the spike vector.
module lif_timestep_scheduler
  import lif_sched_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int M         = 8,
  parameter int EN_CYCLES = 2,
  parameter int SETTLE    = 1,
  parameter int TS_W      = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [M-1:0]         input_spikes,
  input  logic [N_NEURONS-1:0] neuron_spike,
  output logic [M-1:0]         in_spikes_q,
  output logic [IDX_W-1:0]     wt_addr,
  output logic                 wt_rd,
  output logic [N_NEURONS-1:0] neuron_en,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spikes_out,
  output logic [TS_W-1:0]      timestep
);

  localparam int PH_MAX = (EN_CYCLES > SETTLE) ? EN_CYCLES : SETTLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  EN_LOAD     = PH_W'(EN_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LOAD = PH_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_NEURONS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [M-1:0]         in_spikes_d;
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic [N_NEURONS-1:0] spikes_out_q, spikes_out_d;
  logic [TS_W-1:0]      timestep_q, timestep_d;
  logic [IDX_W-1:0]     wt_addr_q, wt_addr_d;
  logic                 wt_rd_q, wt_rd_d;
  logic [N_NEURONS-1:0] neuron_en_q, neuron_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    phase_d      = phase_q;
    in_spikes_d  = in_spikes_q;
    spike_vec_d  = spike_vec_q;
    spikes_out_d = spikes_out_q;
    timestep_d   = timestep_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_spikes_d = input_spikes;
          spike_vec_d = '0;
          idx_d       = '0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        phase_d = EN_LOAD;
        state_d = S_ENABLE;
      end
      S_ENABLE: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PH_W'(1);
        end else if (SETTLE == 0) begin
          state_d = S_CAPTURE;
        end else begin
          phase_d = SETTLE_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (phase_q != '0) phase_d = phase_q - PH_W'(1);
        else               state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        spike_vec_d[idx_q] = neuron_spike[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Publish on the edge into DONE so spikes_out and timestep line up with the done pulse.
    if (state_d == S_DONE) begin
      spikes_out_d = spike_vec_d;
      timestep_d   = timestep_q + TS_W'(1);
    end

    wt_addr_d   = idx_d;
    wt_rd_d     = (state_d == S_FETCH) || (state_d == S_ENABLE);
    neuron_en_d = (state_d == S_ENABLE) ? N_NEURONS'(onehot(32'(idx_d), N_NEURONS)) : '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      phase_q      <= '0;
      in_spikes_q  <= '0;
      spike_vec_q  <= '0;
      spikes_out_q <= '0;
      timestep_q   <= '0;
      wt_addr_q    <= '0;
      wt_rd_q      <= 1'b0;
      neuron_en_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      in_spikes_q  <= in_spikes_d;
      spike_vec_q  <= spike_vec_d;
      spikes_out_q <= spikes_out_d;
      timestep_q   <= timestep_d;
      wt_addr_q    <= wt_addr_d;
      wt_rd_q      <= wt_rd_d;
      neuron_en_q  <= neuron_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign wt_addr    = wt_addr_q;
  assign wt_rd      = wt_rd_q;
  assign neuron_en  = neuron_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spikes_out = spikes_out_q;
  assign timestep   = timestep_q;

endmodule
